// File: rtl/adder_1bit.sv
// Single-bit full adder: combinational sum/carry plus a registered path that
// chains its own carry to add WORD_LEN-bit words LSB-first, one bit per beat.
module adder_1bit #(
  parameter int WORD_LEN = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        a,
  input  logic                        b,
  input  logic                        ci,
  input  logic                        in_valid,
  input  logic                        ser_mode,
  output logic                        sum,
  output logic                        c,
  output logic                        sum_q,
  output logic                        c_q,
  output logic                        out_valid,
  output logic                        word_done,
  output logic [$clog2(WORD_LEN)-1:0] bit_idx
);

  localparam int IDX_W = $clog2(WORD_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  logic             sum_p1;
  logic             c_p1;
  logic             carry_p1;
  logic             vld_p1;
  logic             done_p1;
  logic [IDX_W-1:0] idx_p1;
  logic             cin_eff;
  logic             maj_eff;

  assign sum = a ^ b ^ ci;
  assign c   = maj3(a, b, ci);

  // Bit 0 of a serial word and every independent bit take the external carry.
  assign cin_eff = (ser_mode && (idx_p1 != '0)) ? carry_p1 : ci;
  assign maj_eff = maj3(a, b, cin_eff);

  // ---- stage p1: registered result and word sequencing ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1   <= 1'b0;
      c_p1     <= 1'b0;
      carry_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
      idx_p1   <= '0;
    end else if (in_valid) begin
      sum_p1   <= a ^ b ^ cin_eff;
      c_p1     <= maj_eff;
      carry_p1 <= maj_eff;
      vld_p1   <= 1'b1;
      if (ser_mode) begin
        if (idx_p1 == LAST_IDX) begin
          idx_p1  <= '0;
          done_p1 <= 1'b1;
        end else begin
          idx_p1  <= idx_p1 + 1'b1;
          done_p1 <= 1'b0;
        end
      end else begin
        idx_p1  <= '0;
        done_p1 <= 1'b0;
      end
    end else begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end
  end

  assign sum_q     = sum_p1;
  assign c_q       = c_p1;
  assign out_valid = vld_p1;
  assign word_done = done_p1;
  assign bit_idx   = idx_p1;

endmodule

// File: tb/tb_adder_1bit.sv
// Directed-vector bench for adder_1bit: combinational truth table, independent
// registered bits, serial words with gaps, and asynchronous mid-word reset.
module tb_adder_1bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a = 1'b0, b = 1'b0, ci = 1'b0;
  logic       in_valid = 1'b0, ser_mode = 1'b0;
  logic       sum, c, sum_q, c_q, out_valid, word_done;
  logic [2:0] bit_idx;

  int n_vec = 0;
  int n_err = 0;

  adder_1bit #(.WORD_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .ci(ci),
    .in_valid(in_valid), .ser_mode(ser_mode),
    .sum(sum), .c(c), .sum_q(sum_q), .c_q(c_q),
    .out_valid(out_valid), .word_done(word_done), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one beat at the falling edge; return 1 ns after the next rising edge.
  task automatic beat(input logic ia, input logic ib, input logic ic,
                      input logic iv, input logic sm);
    @(negedge clk);
    a = ia; b = ib; ci = ic; in_valid = iv; ser_mode = sm;
    @(posedge clk);
    #1;
  endtask

  task automatic ser_add(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic cin, input bit gaps,
                         output logic [7:0] s, output logic cout);
    s = '0;
    cout = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(x[i], y[i], cin, 1'b1, 1'b1);
      s[i] = sum_q;
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_done"}, 32'(word_done), (i == 7) ? 32'd1 : 32'd0);
      chk({tag, "_idx"}, 32'(bit_idx), 32'((i + 1) % 8));
      if (i == 7) cout = c_q;
      if (gaps && i < 7) begin
        for (int g = 0; g < (i % 3) + 1; g++) begin
          beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
          chk({tag, "_gap_vld"}, 32'(out_valid), 32'd0);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [7:0] exp_sum = 8'b1001_0110;
  logic [7:0] exp_c   = 8'b1110_1000;
  logic [7:0] s;
  logic       co;

  initial begin
    #50;
    chk("rst_sum_q", 32'(sum_q), 32'd0);
    chk("rst_c_q", 32'(c_q), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(word_done), 32'd0);
    chk("rst_idx", 32'(bit_idx), 32'd0);
    #50;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      {a, b, ci} = 3'(i);
      #1;
      chk($sformatf("comb_sum%0d", i), 32'(sum), 32'(exp_sum[i]));
      chk($sformatf("comb_c%0d", i), 32'(c), 32'(exp_c[i]));
      #9;
    end

    beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("ind0_sum_q", 32'(sum_q), 32'd1);
    chk("ind0_c_q", 32'(c_q), 32'd1);
    chk("ind0_vld", 32'(out_valid), 32'd1);
    chk("ind0_done", 32'(word_done), 32'd0);
    beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ind1_sum_q", 32'(sum_q), 32'd1);
    chk("ind1_c_q", 32'(c_q), 32'd0);
    chk("ind1_vld", 32'(out_valid), 32'd1);
    chk("ind1_idx", 32'(bit_idx), 32'd0);
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_vld", 32'(out_valid), 32'd0);
    chk("idle_hold_sum_q", 32'(sum_q), 32'd1);

    ser_add("a5_3c", 8'hA5, 8'h3C, 1'b0, 1'b0, s, co);
    chk("a5_3c_sum", 32'(s), 32'hE1);
    chk("a5_3c_cout", 32'(co), 32'd0);

    ser_add("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, s, co);
    chk("ff_01_sum", 32'(s), 32'h00);
    chk("ff_01_cout", 32'(co), 32'd1);
    chk("ff_01_idx", 32'(bit_idx), 32'd0);

    ser_add("00_00_ci", 8'h00, 8'h00, 1'b1, 1'b0, s, co);
    chk("00_00_ci_sum", 32'(s), 32'h01);
    chk("00_00_ci_cout", 32'(co), 32'd0);

    ser_add("gap", 8'h3C, 8'h3C, 1'b0, 1'b1, s, co);
    chk("gap_sum", 32'(s), 32'h78);
    chk("gap_cout", 32'(co), 32'd0);

    // Partial serial word abandoned by switching to independent mode.
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("abandon_mid_idx", 32'(bit_idx), 32'd2);
    beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("abandon_idx", 32'(bit_idx), 32'd0);
    chk("abandon_sum_q", 32'(sum_q), 32'd1);
    chk("abandon_c_q", 32'(c_q), 32'd0);

    // Mid-word asynchronous reset after bit 4 of 0xFF + 0x01.
    for (int i = 0; i < 5; i++) beat(1'b1, (i == 0), 1'b0, 1'b1, 1'b1);
    chk("pre_rst_idx", 32'(bit_idx), 32'd5);
    chk("pre_rst_c_q", 32'(c_q), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sum_q", 32'(sum_q), 32'd0);
    chk("arst_c_q", 32'(c_q), 32'd0);
    chk("arst_vld", 32'(out_valid), 32'd0);
    chk("arst_done", 32'(word_done), 32'd0);
    chk("arst_idx", 32'(bit_idx), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    ser_add("post_rst", 8'h01, 8'h02, 1'b1, 1'b0, s, co);
    chk("post_rst_sum", 32'(s), 32'h04);
    chk("post_rst_cout", 32'(co), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
